// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default widths for the I/D line-request arbiter.
//   state_t : arbiter FSM states (IDLE, SERVE_I, SERVE_D)
//   grant_t : identity of a granted requester (GRANT_I, GRANT_D)
//   DEF_ADDR_W / DEF_LINE_W : default address and cache-line widths
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin picker, purely combinational.
//   req[1:0] : in  request vector, bit 0 = I-cache, bit 1 = D-cache
//   last     : in  requester granted most recently
//   gnt[1:0] : out one-hot grant (all zero when nobody requests)
// On a tie the requester that was not granted last time wins.
// ----------------------------------------------------------------------------
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last,
    output logic [1:0] gnt
);

    always_comb begin
        if (req == 2'b11) begin
            gnt = (last == GRANT_I) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/line_mem_arbiter.sv
// ----------------------------------------------------------------------------
// line_mem_arbiter
// Arbitrates 256-bit line traffic from the I-cache and D-cache onto the single
// memory-side cacheline adaptor. One requester is served at a time; its
// request is latched at grant so upstream changes mid-transaction are ignored.
//
// Ports
//   clk, reset_n                  : clock, synchronous active-low reset
//   i_address_i, i_read_i         : I-cache line read request (level)
//   i_line_o, i_resp_o            : read line / completion pulse to I-cache
//   d_address_i, d_read_i,
//   d_write_i, d_line_i           : D-cache line read / writeback request
//   d_line_o, d_resp_o            : read line / completion pulse to D-cache
//   adp_address_o, adp_line_o,
//   adp_read_o, adp_write_o       : request to the cacheline adaptor
//   adp_line_i, adp_resp_i        : read line / completion from the adaptor
// ----------------------------------------------------------------------------
module line_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] i_address_i,
    input  logic              i_read_i,
    output logic [LINE_W-1:0] i_line_o,
    output logic              i_resp_o,

    input  logic [ADDR_W-1:0] d_address_i,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [LINE_W-1:0] d_line_i,
    output logic [LINE_W-1:0] d_line_o,
    output logic              d_resp_o,

    output logic [ADDR_W-1:0] adp_address_o,
    output logic [LINE_W-1:0] adp_line_o,
    output logic              adp_read_o,
    output logic              adp_write_o,
    input  logic [LINE_W-1:0] adp_line_i,
    input  logic              adp_resp_i
);

    state_t              state, state_next;
    grant_t              last_grant, last_grant_next;
    logic [ADDR_W-1:0]   addr_q, addr_next;
    logic [LINE_W-1:0]   line_q, line_next;
    logic                op_write_q, op_write_next;
    logic [1:0]          gnt;

    rr_pick2 u_pick (
        .req  ({d_read_i | d_write_i, i_read_i}),
        .last (last_grant),
        .gnt  (gnt)
    );

    // NOTE: reset is sampled on the clock edge only (synchronous), matching the
    // adaptor which shares reset_n; non-blocking assignments keep every
    // register update consistent within the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            addr_q     <= '0;
            line_q     <= '0;
            op_write_q <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            addr_q     <= addr_next;
            line_q     <= line_next;
            op_write_q <= op_write_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        addr_next       = addr_q;
        line_next       = line_q;
        op_write_next   = op_write_q;
        i_resp_o        = 1'b0;
        d_resp_o        = 1'b0;

        case (state)
            IDLE: begin
                // adp_resp_i is deliberately ignored here: a stray pulse has no owner.
                if (gnt[1]) begin
                    state_next      = SERVE_D;
                    last_grant_next = GRANT_D;
                    addr_next       = d_address_i;
                    line_next       = d_line_i;
                    // A write wins when both read and write are raised.
                    op_write_next   = d_write_i;
                end else if (gnt[0]) begin
                    state_next      = SERVE_I;
                    last_grant_next = GRANT_I;
                    addr_next       = i_address_i;
                    line_next       = '0;
                    op_write_next   = 1'b0;
                end
            end
            SERVE_I: begin
                if (adp_resp_i) begin
                    i_resp_o   = 1'b1;
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                if (adp_resp_i) begin
                    d_resp_o   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Requests are qualified by state, so they drop in the IDLE cycle that
    // follows the adaptor's response and the adaptor never sees a stale one.
    assign adp_read_o    = (state != IDLE) && !op_write_q;
    assign adp_write_o   = (state != IDLE) &&  op_write_q;
    assign adp_address_o = addr_q;
    assign adp_line_o    = line_q;

    // Read lines are mirrored to both caches; only the resp pulses qualify them.
    assign i_line_o = adp_line_i;
    assign d_line_o = adp_line_i;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_line_mem_arbiter
// Directed self-checking bench for line_mem_arbiter. The adaptor is played by
// the stimulus itself: responses are raised at fixed points in the sequence.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_line_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    localparam logic [LINE_W-1:0] LINE_AA = {32{8'hAA}};
    localparam logic [LINE_W-1:0] LINE_55 = {32{8'h55}};
    localparam logic [LINE_W-1:0] LINE_C3 = {32{8'hC3}};
    localparam logic [LINE_W-1:0] LINE_WR = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [LINE_W-1:0] LINE_X  = {4{64'hDEAD_BEEF_F00D_CAFE}};

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] i_address_i;
    logic              i_read_i;
    logic [LINE_W-1:0] i_line_o;
    logic              i_resp_o;
    logic [ADDR_W-1:0] d_address_i;
    logic              d_read_i;
    logic              d_write_i;
    logic [LINE_W-1:0] d_line_i;
    logic [LINE_W-1:0] d_line_o;
    logic              d_resp_o;
    logic [ADDR_W-1:0] adp_address_o;
    logic [LINE_W-1:0] adp_line_o;
    logic              adp_read_o;
    logic              adp_write_o;
    logic [LINE_W-1:0] adp_line_i;
    logic              adp_resp_i;

    int checks   = 0;
    int failures = 0;

    line_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_address_i   (i_address_i),
        .i_read_i      (i_read_i),
        .i_line_o      (i_line_o),
        .i_resp_o      (i_resp_o),
        .d_address_i   (d_address_i),
        .d_read_i      (d_read_i),
        .d_write_i     (d_write_i),
        .d_line_i      (d_line_i),
        .d_line_o      (d_line_o),
        .d_resp_o      (d_resp_o),
        .adp_address_o (adp_address_o),
        .adp_line_o    (adp_line_o),
        .adp_read_o    (adp_read_o),
        .adp_write_o   (adp_write_o),
        .adp_line_i    (adp_line_i),
        .adp_resp_i    (adp_resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        i_address_i = '0;
        i_read_i    = 1'b0;
        d_address_i = '0;
        d_read_i    = 1'b0;
        d_write_i   = 1'b0;
        d_line_i    = '0;
        adp_line_i  = '0;
        adp_resp_i  = 1'b0;

        // ---- reset state
        step();
        step();
        check("rst_state", dut.state, IDLE);
        check("rst_read",  adp_read_o, 0);
        check("rst_write", adp_write_o, 0);
        check("rst_addr",  adp_address_o, 0);
        check("rst_line",  adp_line_o, 0);
        check("rst_iresp", i_resp_o, 0);
        check("rst_dresp", d_resp_o, 0);
        reset_n = 1'b1;
        step();

        // ---- I-cache alone reads 0x1000, adaptor answers after 6 cycles
        i_address_i = 32'h0000_1000;
        i_read_i    = 1'b1;
        step();
        check("i1_read",  adp_read_o, 1);
        check("i1_write", adp_write_o, 0);
        check("i1_addr",  adp_address_o, 32'h0000_1000);
        for (int k = 0; k < 5; k++) begin
            check("i1_wait_iresp", i_resp_o, 0);
            check("i1_wait_read",  adp_read_o, 1);
            step();
        end
        adp_line_i = LINE_AA;
        adp_resp_i = 1'b1;
        settle();
        check("i1_iresp", i_resp_o, 1);
        check("i1_iline", i_line_o, LINE_AA);
        check("i1_dresp", d_resp_o, 0);
        step();
        adp_resp_i = 1'b0;
        i_read_i   = 1'b0;
        settle();
        check("i1_iresp_once", i_resp_o, 0);
        check("i1_read_drop",  adp_read_o, 0);
        check("i1_idle",       dut.state, IDLE);

        // ---- D-cache writeback to 0x2000, data changes upstream mid-transaction
        d_address_i = 32'h0000_2000;
        d_line_i    = LINE_WR;
        d_write_i   = 1'b1;
        step();
        check("dw_write", adp_write_o, 1);
        check("dw_read",  adp_read_o, 0);
        check("dw_addr",  adp_address_o, 32'h0000_2000);
        check("dw_line",  adp_line_o, LINE_WR);
        d_line_i    = LINE_X;
        d_address_i = 32'h0000_DEAD;
        for (int k = 0; k < 3; k++) begin
            step();
            check("dw_line_hold", adp_line_o, LINE_WR);
            check("dw_addr_hold", adp_address_o, 32'h0000_2000);
        end
        adp_resp_i = 1'b1;
        settle();
        check("dw_dresp", d_resp_o, 1);
        check("dw_iresp", i_resp_o, 0);
        step();
        adp_resp_i = 1'b0;
        d_write_i  = 1'b0;
        settle();
        check("dw_dresp_once", d_resp_o, 0);
        check("dw_write_drop", adp_write_o, 0);

        // ---- simultaneous requests after reset: D first, then I, then D again
        reset_n = 1'b0;
        step();
        reset_n     = 1'b1;
        i_address_i = 32'h0000_3000;
        d_address_i = 32'h0000_4000;
        i_read_i    = 1'b1;
        d_read_i    = 1'b1;
        step();
        check("tie1_state", dut.state, SERVE_D);
        check("tie1_addr",  adp_address_o, 32'h0000_4000);
        check("tie1_read",  adp_read_o, 1);
        adp_line_i = LINE_55;
        adp_resp_i = 1'b1;
        settle();
        check("tie1_dresp", d_resp_o, 1);
        check("tie1_dline", d_line_o, LINE_55);
        check("tie1_iresp", i_resp_o, 0);
        step();
        adp_resp_i = 1'b0;
        d_read_i   = 1'b0;
        settle();
        check("tie1_gap_idle", dut.state, IDLE);
        check("tie1_gap_read", adp_read_o, 0);
        step();
        check("tie1_then_i", dut.state, SERVE_I);
        check("tie1_i_addr", adp_address_o, 32'h0000_3000);
        adp_line_i = LINE_C3;
        adp_resp_i = 1'b1;
        settle();
        check("tie1_i_iresp", i_resp_o, 1);
        check("tie1_i_iline", i_line_o, LINE_C3);
        step();
        adp_resp_i  = 1'b0;
        i_address_i = 32'h0000_5000;
        d_address_i = 32'h0000_6000;
        i_read_i    = 1'b1;
        d_read_i    = 1'b1;
        settle();
        check("tie2_idle", dut.state, IDLE);
        step();
        check("tie2_state", dut.state, SERVE_D);
        check("tie2_addr",  adp_address_o, 32'h0000_6000);
        adp_resp_i = 1'b1;
        settle();
        check("tie2_dresp", d_resp_o, 1);
        step();
        adp_resp_i = 1'b0;
        i_read_i   = 1'b0;
        d_read_i   = 1'b0;
        step();
        check("tie2_quiet", dut.state, IDLE);

        // ---- read and write both set: issued as a write
        d_address_i = 32'h0000_7000;
        d_line_i    = LINE_C3;
        d_read_i    = 1'b1;
        d_write_i   = 1'b1;
        step();
        check("rw_write", adp_write_o, 1);
        check("rw_read",  adp_read_o, 0);
        check("rw_line",  adp_line_o, LINE_C3);
        adp_resp_i = 1'b1;
        settle();
        check("rw_dresp", d_resp_o, 1);
        step();
        adp_resp_i = 1'b0;
        d_read_i   = 1'b0;
        d_write_i  = 1'b0;
        step();

        // ---- reset during SERVE_I abandons the request
        i_address_i = 32'h0000_8000;
        i_read_i    = 1'b1;
        step();
        check("rst_mid_serve", dut.state, SERVE_I);
        reset_n = 1'b0;
        step();
        check("rst_mid_state", dut.state, IDLE);
        check("rst_mid_read",  adp_read_o, 0);
        check("rst_mid_write", adp_write_o, 0);
        check("rst_mid_addr",  adp_address_o, 0);
        check("rst_mid_line",  adp_line_o, 0);
        check("rst_mid_iresp", i_resp_o, 0);
        reset_n  = 1'b1;
        i_read_i = 1'b0;
        step();
        check("rst_mid_quiet", adp_read_o, 0);
        i_address_i = 32'h0000_9000;
        i_read_i    = 1'b1;
        step();
        check("post_rst_read", adp_read_o, 1);
        check("post_rst_addr", adp_address_o, 32'h0000_9000);
        adp_line_i = LINE_AA;
        adp_resp_i = 1'b1;
        settle();
        check("post_rst_iresp", i_resp_o, 1);
        check("post_rst_iline", i_line_o, LINE_AA);
        step();
        adp_resp_i = 1'b0;
        i_read_i   = 1'b0;
        step();

        // ---- stray adaptor response while idle
        adp_resp_i = 1'b1;
        settle();
        check("stray_iresp", i_resp_o, 0);
        check("stray_dresp", d_resp_o, 0);
        step();
        check("stray_state", dut.state, IDLE);
        check("stray_read",  adp_read_o, 0);
        adp_resp_i = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Two-port line-request arbiter between the instruction cache and data cache and the single memory-side `cacheline_adaptor`. It accepts 256-bit line reads from the I-cache and line reads/writes from the D-cache, and grants one requester at a time using round-robin on ties. It latches the granted request and drives the adaptor's LLC port until the adaptor's response, then routes the response and read line back to the owner.

## Interface
- `ADDR_W`, 32, address width
- `LINE_W`, 256, cache line width
- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `i_address_i`  in  ADDR_W  I-cache line address
- `i_read_i`  in  1  I-cache line read request (level, held until `i_resp_o`)
- `i_line_o`  out  LINE_W  read line to I-cache, valid only while `i_resp_o`=1
- `i_resp_o`  out  1  I-cache completion pulse
- `d_address_i`  in  ADDR_W  D-cache line address
- `d_read_i`  in  1  D-cache line read request
- `d_write_i`  in  1  D-cache line write (writeback) request
- `d_line_i`  in  LINE_W  D-cache writeback data
- `d_line_o`  out  LINE_W  read line to D-cache, valid only while `d_resp_o`=1
- `d_resp_o`  out  1  D-cache completion pulse
- `adp_address_o`  out  ADDR_W  address to adaptor
- `adp_line_o`  out  LINE_W  write line to adaptor
- `adp_read_o`  out  1  read request to adaptor
- `adp_write_o`  out  1  write request to adaptor
- `adp_line_i`  in  LINE_W  read line from adaptor
- `adp_resp_i`  in  1  adaptor completion pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- Request vectors: `req_i = i_read_i`; `req_d = d_read_i | d_write_i`.
- IDLE:
  - If only one requester is active, grant it.
  - If both are active, grant the requester not recorded in `last_grant`.
  - On grant, latch address, operation (`op_write`), and write line (D only; `d_write_i` wins if `d_read_i` is also set). Set `last_grant`. Go to SERVE_x.
- SERVE_x:
  - `adp_address_o`/`adp_line_o` come from the latches; `adp_read_o = !op_write`, `adp_write_o = op_write`.
  - On `adp_resp_i`=1: assert `x_resp_o` combinationally in the same cycle with `x_line_o = adp_line_i`, then go to IDLE at the next edge.
- Inputs from the served requester are ignored after grant. The latches hold, so upstream changes mid-transaction have no effect.
- The non-owner's `resp_o` is always 0. `i_line_o`/`d_line_o` may mirror `adp_line_i` at all times; only `resp_o` qualifies them.
- `adp_resp_i` in IDLE is ignored (no upstream pulse).
- Reset values:
  - state IDLE; `last_grant` = I, so D wins the first tie.
  - latches 0; all `adp_*_o` 0; both `resp_o` 0.
- Reset mid-transaction: return to IDLE and abandon the latched request. The adaptor shares `reset_n` and resets consistently.

## Timing
- Grant latency: a request visible in IDLE at edge N is driven on `adp_*` in cycle N+1.
- Adaptor requests are deasserted the cycle after `adp_resp_i`. This guarantees the adaptor, back in its wait state, does not see a stale request.
- There is at least one IDLE cycle between consecutive transactions.
- The requester drops its request in the cycle after `resp_o`. Under that rule, back-to-back requests from the same cache are re-arbitrated normally.
- Write data stays stable on `adp_line_o` for the whole SERVE_D, as required by the adaptor's per-cycle line capture.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE, SERVE_I, SERVE_D), grant enum (GRANT_I, GRANT_D), `ADDR_W`/`LINE_W` defaults.
- Optional sub-module `rr_pick2`: a 2-way round-robin picker (`req[1:0]`, `last`, outputs `gnt`). Everything else stays in one module.

## Test plan
- I-cache alone reads `0x0000_1000`; adaptor responds after 6 cycles with line `0xAA..AA`:
  - `adp_read_o`=1 with address `0x1000` from the cycle after the request.
  - `i_resp_o`=1 for exactly 1 cycle with `i_line_o`=`0xAA..AA`; `d_resp_o` stays 0.
- D-cache writes line `0x0123..CDEF` to `0x0000_2000`; upstream changes `d_line_i` mid-transaction:
  - `adp_write_o`=1, address `0x2000`, `adp_line_o` holds `0x0123..CDEF` throughout.
  - `d_resp_o` pulses once.
- Both request in the same cycle after reset:
  - D is served first; I is granted in the IDLE cycle after D's response.
  - A second simultaneous tie then goes to D again (last grant was I).
- D read with `d_read_i` and `d_write_i` both set: the transaction issues as a write (`adp_write_o`=1, `adp_read_o`=0).
- `reset_n`=0 during SERVE_I:
  - The next cycle shows state IDLE and all `adp_*_o`=0.
  - No `i_resp_o` is issued; a new request afterwards completes normally.
- Stray `adp_resp_i` pulse in IDLE: no `resp_o` on either port; state remains IDLE.
